// File: rtl/ethernet_multislot_control_unit.sv
// Multi-slot Ethernet MMIO control unit.
// Decodes CPU MMIO accesses into RX slot buffers (read), TX slot buffers (write) and a
// Liteeth-style register file. Tracks committed RX packets in a ring of {slot, length}
// entries and queues TX send commands in a FIFO. Drives a merged level interrupt.
// Ports:
//   clk_i, reset_i              clock, asynchronous active-high reset
//   addr_i, read_en_i,          MMIO byte address and one-cycle strobes, access size,
//   write_en_i, op_size_i,      write data
//   write_data_i
//   read_data_o                 read data, valid the cycle after read_en_i
//   io_decode_error_o           combinational decode error for the current strobe
//   buf_r_*, buf_rdata_i        synchronous RX buffer read port
//   buf_w_*                     TX buffer write port
//   rx_free_v_o/rx_free_slot_o  next RX slot the MAC may fill
//   rx_commit_i/_size_i         MAC completed a packet in rx_free_slot_o
//   tx_cmd_*                    TX command FIFO head, popped by tx_cmd_yumi_i
//   tx_done_i                   MAC finished transmitting a packet
//   irq_o                       level interrupt
module ethernet_multislot_control_unit #(
  parameter int unsigned eth_mtu_p    = 2048,
  parameter int unsigned rx_slots_p   = 2,
  parameter int unsigned tx_slots_p   = 2,
  parameter int unsigned data_width_p = 32,
  localparam int unsigned size_width_lp     = $clog2($clog2(data_width_p / 8) + 1),
  localparam int unsigned pkt_size_width_lp = $clog2(eth_mtu_p + 1),
  localparam int unsigned rx_bytes_lp       = rx_slots_p * eth_mtu_p,
  localparam int unsigned tx_bytes_lp       = tx_slots_p * eth_mtu_p,
  localparam int unsigned reg_base_lp       = rx_bytes_lp + tx_bytes_lp,
  localparam int unsigned addr_width_lp     = $clog2(reg_base_lp + 64),
  localparam int unsigned rx_slot_width_lp  = (rx_slots_p > 1) ? $clog2(rx_slots_p) : 1,
  localparam int unsigned tx_slot_width_lp  = (tx_slots_p > 1) ? $clog2(tx_slots_p) : 1,
  localparam int unsigned rx_buf_aw_lp      = $clog2(rx_bytes_lp),
  localparam int unsigned tx_buf_aw_lp      = $clog2(tx_bytes_lp)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [addr_width_lp-1:0]     addr_i,
  input  logic                         read_en_i,
  input  logic                         write_en_i,
  input  logic [size_width_lp-1:0]     op_size_i,
  input  logic [data_width_p-1:0]      write_data_i,
  output logic [data_width_p-1:0]      read_data_o,
  output logic                         io_decode_error_o,
  output logic                         buf_r_v_o,
  output logic [rx_buf_aw_lp-1:0]      buf_r_addr_o,
  output logic [size_width_lp-1:0]     buf_r_size_o,
  input  logic [data_width_p-1:0]      buf_rdata_i,
  output logic                         buf_w_v_o,
  output logic [tx_buf_aw_lp-1:0]      buf_w_addr_o,
  output logic [size_width_lp-1:0]     buf_w_size_o,
  output logic [data_width_p-1:0]      buf_w_data_o,
  output logic                         rx_free_v_o,
  output logic [rx_slot_width_lp-1:0]  rx_free_slot_o,
  input  logic                         rx_commit_i,
  input  logic [pkt_size_width_lp-1:0] rx_commit_size_i,
  output logic                         tx_cmd_v_o,
  output logic [tx_slot_width_lp-1:0]  tx_cmd_slot_o,
  output logic [pkt_size_width_lp-1:0] tx_cmd_size_o,
  input  logic                         tx_cmd_yumi_i,
  input  logic                         tx_done_i,
  output logic                         irq_o
);

  localparam int unsigned rx_cnt_width_lp = $clog2(rx_slots_p + 1);
  localparam int unsigned tx_cnt_width_lp = $clog2(tx_slots_p + 1);

  // RX ring: the slot of an entry equals its ring index, so only lengths are stored.
  logic [pkt_size_width_lp-1:0] rx_len_mem [rx_slots_p];
  logic [rx_slot_width_lp-1:0]  rx_wr_ptr_q, rx_rd_ptr_q;
  logic [rx_cnt_width_lp-1:0]   rx_count_q;
  logic [15:0]                  rx_drop_q;
  logic                         rx_en_q;

  logic [tx_slot_width_lp-1:0]  tx_slot_mem [tx_slots_p];
  logic [pkt_size_width_lp-1:0] tx_len_mem  [tx_slots_p];
  logic [tx_slot_width_lp-1:0]  tx_wr_ptr_q, tx_rd_ptr_q;
  logic [tx_cnt_width_lp-1:0]   tx_count_q;
  logic [tx_slot_width_lp-1:0]  tx_slot_q;
  logic [pkt_size_width_lp-1:0] tx_len_q;
  logic                         tx_pend_q, tx_en_q;

  logic                         rd_buf_q;
  logic [data_width_p-1:0]      rd_data_q;

  logic                     in_rx, in_tx, in_reg;
  logic [addr_width_lp-1:0] reg_off;
  logic [5:0]               off;
  logic [31:0]              wdata32, reg_rdata;
  logic                     reg_rd_ok, reg_wr_ok, rd_v, wr_v, reg_we;
  logic                     rx_full, tx_full, rx_pop, rx_push, rx_drop, tx_push, tx_pop;

  assign wdata32 = write_data_i[31:0];
  assign reg_off = addr_i - addr_width_lp'(reg_base_lp);
  assign off     = reg_off[5:0];
  assign in_rx   = addr_i < addr_width_lp'(rx_bytes_lp);
  assign in_tx   = !in_rx && (addr_i < addr_width_lp'(reg_base_lp));
  assign in_reg  = !in_rx && !in_tx && (reg_off < addr_width_lp'(64));

  assign rx_full = rx_count_q == rx_cnt_width_lp'(rx_slots_p);
  assign tx_full = tx_count_q == tx_cnt_width_lp'(tx_slots_p);

  always_comb begin
    reg_rd_ok = 1'b0;
    reg_wr_ok = 1'b0;
    reg_rdata = '0;
    case (off)
      6'h00: begin
        reg_rd_ok = 1'b1;
        if (rx_count_q != '0) reg_rdata = 32'(rx_rd_ptr_q);
      end
      6'h04: begin
        reg_rd_ok = 1'b1;
        if (rx_count_q != '0) reg_rdata = 32'(rx_len_mem[rx_rd_ptr_q]);
      end
      6'h08: begin reg_rd_ok = 1'b1; reg_rdata = 32'(rx_drop_q); end
      6'h10: begin reg_rd_ok = 1'b1; reg_wr_ok = 1'b1; reg_rdata = 32'(rx_count_q != '0); end
      6'h14: begin reg_rd_ok = 1'b1; reg_wr_ok = 1'b1; reg_rdata = 32'(rx_en_q); end
      // A start on a full FIFO is fine if the head leaves in the same cycle.
      6'h18: reg_wr_ok = !tx_full || tx_cmd_yumi_i;
      6'h1C: begin reg_rd_ok = 1'b1; reg_rdata = 32'(!tx_full); end
      6'h20: begin reg_rd_ok = 1'b1; reg_rdata = 32'(tx_count_q); end
      6'h24: begin
        reg_rd_ok = 1'b1;
        reg_wr_ok = wdata32 < 32'(tx_slots_p);
        reg_rdata = 32'(tx_slot_q);
      end
      6'h28: begin
        reg_rd_ok = 1'b1;
        reg_wr_ok = wdata32 <= 32'(eth_mtu_p);
        reg_rdata = 32'(tx_len_q);
      end
      6'h30: begin reg_rd_ok = 1'b1; reg_wr_ok = 1'b1; reg_rdata = 32'(tx_pend_q); end
      6'h34: begin reg_rd_ok = 1'b1; reg_wr_ok = 1'b1; reg_rdata = 32'(tx_en_q); end
      default: ;
    endcase
  end

  assign io_decode_error_o = (read_en_i && write_en_i)
                          || (read_en_i && !(in_rx || (in_reg && reg_rd_ok)))
                          || (write_en_i && !(in_tx || (in_reg && reg_wr_ok)));
  assign rd_v   = read_en_i && !io_decode_error_o;
  assign wr_v   = write_en_i && !io_decode_error_o;
  assign reg_we = wr_v && in_reg;

  assign rx_pop  = reg_we && (off == 6'h10) && wdata32[0] && (rx_count_q != '0);
  // A same-cycle pop frees the slot being committed into, so the commit is kept.
  assign rx_push = rx_commit_i && (!rx_full || rx_pop);
  assign rx_drop = rx_commit_i && !rx_push;
  assign tx_push = reg_we && (off == 6'h18);
  assign tx_pop  = tx_cmd_yumi_i && (tx_count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_len_mem[rx_wr_ptr_q] <= rx_commit_size_i;
    if (tx_push) begin
      tx_slot_mem[tx_wr_ptr_q] <= tx_slot_q;
      tx_len_mem[tx_wr_ptr_q]  <= tx_len_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rx_drop_q   <= '0;
      rx_en_q     <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      tx_slot_q   <= '0;
      tx_len_q    <= '0;
      tx_pend_q   <= 1'b0;
      tx_en_q     <= 1'b0;
      rd_buf_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr_q <= (rx_wr_ptr_q == rx_slot_width_lp'(rx_slots_p - 1)) ? '0
                     : rx_wr_ptr_q + rx_slot_width_lp'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr_q <= (rx_rd_ptr_q == rx_slot_width_lp'(rx_slots_p - 1)) ? '0
                     : rx_rd_ptr_q + rx_slot_width_lp'(1);
      end
      if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + rx_cnt_width_lp'(1);
      else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - rx_cnt_width_lp'(1);
      if (rx_drop && (rx_drop_q != 16'hFFFF)) rx_drop_q <= rx_drop_q + 16'd1;

      if (tx_push) begin
        tx_wr_ptr_q <= (tx_wr_ptr_q == tx_slot_width_lp'(tx_slots_p - 1)) ? '0
                     : tx_wr_ptr_q + tx_slot_width_lp'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr_q <= (tx_rd_ptr_q == tx_slot_width_lp'(tx_slots_p - 1)) ? '0
                     : tx_rd_ptr_q + tx_slot_width_lp'(1);
      end
      if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + tx_cnt_width_lp'(1);
      else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - tx_cnt_width_lp'(1);

      if (reg_we && (off == 6'h14)) rx_en_q   <= wdata32[0];
      if (reg_we && (off == 6'h34)) tx_en_q   <= wdata32[0];
      if (reg_we && (off == 6'h24)) tx_slot_q <= wdata32[tx_slot_width_lp-1:0];
      if (reg_we && (off == 6'h28)) tx_len_q  <= wdata32[pkt_size_width_lp-1:0];
      // Completion wins over a same-cycle W1 clear so no done event is lost.
      if (tx_done_i) tx_pend_q <= 1'b1;
      else if (reg_we && (off == 6'h30) && wdata32[0]) tx_pend_q <= 1'b0;

      if (read_en_i) begin
        rd_buf_q  <= rd_v && in_rx;
        rd_data_q <= (rd_v && in_reg) ? data_width_p'(reg_rdata) : '0;
      end
    end
  end

  assign read_data_o = rd_buf_q ? buf_rdata_i : rd_data_q;

  assign buf_r_v_o    = rd_v && in_rx;
  assign buf_r_addr_o = buf_r_v_o ? addr_i[rx_buf_aw_lp-1:0] : '0;
  assign buf_r_size_o = buf_r_v_o ? op_size_i : '0;
  assign buf_w_v_o    = wr_v && in_tx;
  assign buf_w_addr_o = buf_w_v_o ? tx_buf_aw_lp'(addr_i - addr_width_lp'(rx_bytes_lp)) : '0;
  assign buf_w_size_o = buf_w_v_o ? op_size_i : '0;
  assign buf_w_data_o = buf_w_v_o ? write_data_i : '0;

  assign rx_free_v_o    = !rx_full;
  assign rx_free_slot_o = rx_wr_ptr_q;
  assign tx_cmd_v_o     = tx_count_q != '0;
  assign tx_cmd_slot_o  = tx_cmd_v_o ? tx_slot_mem[tx_rd_ptr_q] : '0;
  assign tx_cmd_size_o  = tx_cmd_v_o ? tx_len_mem[tx_rd_ptr_q] : '0;

  assign irq_o = ((rx_count_q != '0) && rx_en_q) || (tx_pend_q && tx_en_q);

endmodule

// File: tb/tb_ethernet_multislot_control_unit.sv
module tb_ethernet_multislot_control_unit;

  localparam logic [13:0] RegBase = 14'h2000;
  localparam logic [13:0] TxBase  = 14'd4096;

  logic        clk, reset;
  logic [13:0] addr;
  logic        read_en, write_en;
  logic [1:0]  op_size;
  logic [31:0] write_data, read_data, buf_rdata, buf_w_data;
  logic        dec_err, buf_r_v, buf_w_v;
  logic [11:0] buf_r_addr, buf_w_addr;
  logic [1:0]  buf_r_size, buf_w_size;
  logic        rx_free_v, rx_commit, tx_cmd_v, tx_cmd_yumi, tx_done, irq;
  logic [0:0]  rx_free_slot, tx_cmd_slot;
  logic [11:0] rx_commit_size, tx_cmd_size;

  int vectors = 0;
  int miscompares = 0;

  ethernet_multislot_control_unit dut (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .read_en_i(read_en), .write_en_i(write_en),
    .op_size_i(op_size), .write_data_i(write_data), .read_data_o(read_data),
    .io_decode_error_o(dec_err), .buf_r_v_o(buf_r_v), .buf_r_addr_o(buf_r_addr),
    .buf_r_size_o(buf_r_size), .buf_rdata_i(buf_rdata), .buf_w_v_o(buf_w_v),
    .buf_w_addr_o(buf_w_addr), .buf_w_size_o(buf_w_size), .buf_w_data_o(buf_w_data),
    .rx_free_v_o(rx_free_v), .rx_free_slot_o(rx_free_slot), .rx_commit_i(rx_commit),
    .rx_commit_size_i(rx_commit_size), .tx_cmd_v_o(tx_cmd_v), .tx_cmd_slot_o(tx_cmd_slot),
    .tx_cmd_size_o(tx_cmd_size), .tx_cmd_yumi_i(tx_cmd_yumi), .tx_done_i(tx_done), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RX buffer model: data is a fixed function of the address.
  always_ff @(posedge clk) begin
    if (buf_r_v) buf_rdata <= 32'hA500_0000 | 32'(buf_r_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio(input logic wr, input logic [13:0] a, input logic [31:0] d,
                      output logic e, output logic [31:0] rd);
    @(negedge clk);
    addr = a; write_en = wr; read_en = !wr; write_data = d; op_size = 2'd2;
    #1 e = dec_err;
    @(posedge clk);
    #1;
    read_en = 1'b0; write_en = 1'b0;
    rd = read_data;
  endtask

  typedef struct {
    bit          wr;
    logic [13:0] a;
    logic [31:0] d;
    bit          exp_err;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  typedef struct {int slot; int len;} ent_t;

  initial begin
    vec_t        tbl[$];
    ent_t        rxq[$], txq[$];
    logic        e;
    logic [31:0] r;
    int rx_wr, drops, slot_r, len_r;
    bit rx_en, tx_en, pend;
    logic [5:0] offs[13];

    reset = 1'b1; addr = '0; read_en = 0; write_en = 0; op_size = 0; write_data = 0;
    rx_commit = 0; rx_commit_size = 0; tx_cmd_yumi = 0; tx_done = 0;
    #12;
    check("reset_free_v", 32'(rx_free_v), 1);
    check("reset_irq", 32'(irq), 0);
    @(negedge clk) reset = 1'b0;

    // Register-file decode table from reset state.
    tbl.push_back('{0, RegBase + 14'h00, 0, 0, 0, "rx_slot"});
    tbl.push_back('{0, RegBase + 14'h04, 0, 0, 0, "rx_len"});
    tbl.push_back('{0, RegBase + 14'h08, 0, 0, 0, "rx_err"});
    tbl.push_back('{0, RegBase + 14'h10, 0, 0, 0, "rx_pend"});
    tbl.push_back('{0, RegBase + 14'h14, 0, 0, 0, "rx_en"});
    tbl.push_back('{0, RegBase + 14'h18, 0, 1, 0, "rd_tx_start"});
    tbl.push_back('{0, RegBase + 14'h1C, 0, 0, 1, "tx_ready"});
    tbl.push_back('{0, RegBase + 14'h20, 0, 0, 0, "tx_level"});
    tbl.push_back('{0, RegBase + 14'h24, 0, 0, 0, "tx_slot"});
    tbl.push_back('{0, RegBase + 14'h28, 0, 0, 0, "tx_len"});
    tbl.push_back('{0, RegBase + 14'h30, 0, 0, 0, "tx_pend"});
    tbl.push_back('{0, RegBase + 14'h34, 0, 0, 0, "tx_en"});
    tbl.push_back('{0, RegBase + 14'h0C, 0, 1, 0, "rd_unmapped"});
    tbl.push_back('{0, TxBase + 14'd8, 0, 1, 0, "rd_tx_region"});
    tbl.push_back('{1, 14'd16, 5, 1, 0, "wr_rx_region"});
    tbl.push_back('{1, RegBase + 14'h00, 1, 1, 0, "wr_rx_slot"});
    tbl.push_back('{1, RegBase + 14'h1C, 1, 1, 0, "wr_tx_ready"});
    tbl.push_back('{1, RegBase + 14'h24, 2, 1, 0, "wr_slot_2"});
    tbl.push_back('{1, RegBase + 14'h28, 2049, 1, 0, "wr_len_2049"});
    tbl.push_back('{0, RegBase + 14'h28, 0, 0, 0, "len_unchanged"});
    tbl.push_back('{1, RegBase + 14'h28, 2048, 0, 0, "wr_len_2048"});
    tbl.push_back('{0, RegBase + 14'h28, 0, 0, 2048, "len_2048"});
    foreach (tbl[i]) begin
      mmio(tbl[i].wr, tbl[i].a, tbl[i].d, e, r);
      check({tbl[i].name, "_err"}, 32'(e), 32'(tbl[i].exp_err));
      if (!tbl[i].wr) check(tbl[i].name, r, tbl[i].exp_rd);
    end

    // Simultaneous strobes.
    @(negedge clk);
    addr = RegBase + 14'h14; read_en = 1; write_en = 1; write_data = 1;
    #1 check("both_strobes_err", 32'(dec_err), 1);
    tick(); read_en = 0; write_en = 0;
    mmio(0, RegBase + 14'h14, 0, e, r); check("rx_en_untouched", r, 0);

    // RX ring.
    check("rx_free_slot0", 32'(rx_free_slot), 0);
    rx_commit = 1; rx_commit_size = 60; tick();
    rx_commit_size = 1514; tick();
    rx_commit = 0;
    check("rx_full", 32'(rx_free_v), 0);
    rx_commit = 1; rx_commit_size = 7; tick(); rx_commit = 0;
    mmio(0, RegBase + 14'h08, 0, e, r); check("rx_drops", r, 1);
    mmio(0, RegBase + 14'h04, 0, e, r); check("rx_head_len", r, 60);
    mmio(0, RegBase + 14'h00, 0, e, r); check("rx_head_slot", r, 0);
    rx_commit = 1; rx_commit_size = 200;
    mmio(1, RegBase + 14'h10, 1, e, r);
    rx_commit = 0;
    check("pop_commit_err", 32'(e), 0);
    check("pop_commit_full", 32'(rx_free_v), 0);
    mmio(0, RegBase + 14'h00, 0, e, r); check("rx_slot_after_pop", r, 1);
    mmio(0, RegBase + 14'h04, 0, e, r); check("rx_len_after_pop", r, 1514);
    mmio(1, RegBase + 14'h10, 1, e, r);
    check("rx_free_after_pop", 32'(rx_free_v), 1);
    check("rx_free_slot1", 32'(rx_free_slot), 1);
    mmio(0, RegBase + 14'h00, 0, e, r); check("rx_reissued_slot", r, 0);
    mmio(0, RegBase + 14'h04, 0, e, r); check("rx_reissued_len", r, 200);
    mmio(1, RegBase + 14'h10, 1, e, r);
    mmio(1, RegBase + 14'h10, 1, e, r); check("pop_empty_err", 32'(e), 0);
    mmio(0, RegBase + 14'h04, 0, e, r); check("rx_empty_len", r, 0);

    // TX FIFO.
    mmio(1, RegBase + 14'h24, 1, e, r);
    mmio(1, RegBase + 14'h28, 100, e, r);
    mmio(1, RegBase + 14'h18, 1, e, r); check("start1_err", 32'(e), 0);
    mmio(1, RegBase + 14'h18, 1, e, r); check("start2_err", 32'(e), 0);
    mmio(0, RegBase + 14'h1C, 0, e, r); check("tx_ready_full", r, 0);
    mmio(0, RegBase + 14'h20, 0, e, r); check("tx_level_2", r, 2);
    mmio(1, RegBase + 14'h18, 1, e, r); check("start_full_err", 32'(e), 1);
    mmio(0, RegBase + 14'h20, 0, e, r); check("tx_level_still_2", r, 2);
    check("tx_cmd_v", 32'(tx_cmd_v), 1);
    check("tx_cmd_slot", 32'(tx_cmd_slot), 1);
    check("tx_cmd_size", 32'(tx_cmd_size), 100);
    tx_cmd_yumi = 1; tick(); tx_cmd_yumi = 0;
    mmio(0, RegBase + 14'h20, 0, e, r); check("tx_level_1", r, 1);
    tx_cmd_yumi = 1; tick(); tx_cmd_yumi = 0;
    check("tx_empty", 32'(tx_cmd_v), 0);

    // TX pending interrupt.
    mmio(1, RegBase + 14'h34, 1, e, r);
    check("irq_idle", 32'(irq), 0);
    tx_done = 1; tick(); tx_done = 0;
    check("irq_done", 32'(irq), 1);
    tx_done = 1; mmio(1, RegBase + 14'h30, 1, e, r); tx_done = 0;
    check("irq_set_wins", 32'(irq), 1);
    mmio(1, RegBase + 14'h30, 1, e, r);
    check("irq_cleared", 32'(irq), 0);

    // Buffer access.
    @(negedge clk);
    addr = 14'd2052; read_en = 1; op_size = 2;
    #1;
    check("buf_r_v", 32'(buf_r_v), 1);
    check("buf_r_addr", 32'(buf_r_addr), 2052);
    check("buf_rd_err", 32'(dec_err), 0);
    tick(); read_en = 0;
    check("buf_rdata", read_data, 32'hA500_0804);
    @(negedge clk);
    write_en = 1; write_data = 32'h1234;
    #1;
    check("buf_wr_rx_err", 32'(dec_err), 1);
    check("buf_wr_rx_v", 32'(buf_w_v), 0);
    addr = TxBase + 14'd8;
    #1;
    check("buf_w_v", 32'(buf_w_v), 1);
    check("buf_w_addr", 32'(buf_w_addr), 8);
    tick(); write_en = 0;

    // Asynchronous reset with ring and FIFO occupied.
    rx_commit = 1; rx_commit_size = 10; tick(); rx_commit_size = 20; tick(); rx_commit = 0;
    mmio(1, RegBase + 14'h24, 0, e, r);
    mmio(1, RegBase + 14'h28, 5, e, r);
    mmio(1, RegBase + 14'h18, 1, e, r);
    mmio(1, RegBase + 14'h14, 1, e, r);
    mmio(0, RegBase + 14'h04, 0, e, r); check("pre_reset_len", r, 10);
    check("pre_reset_irq", 32'(irq), 1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("arst_free_v", 32'(rx_free_v), 1);
    check("arst_free_slot", 32'(rx_free_slot), 0);
    check("arst_tx_v", 32'(tx_cmd_v), 0);
    check("arst_tx_size", 32'(tx_cmd_size), 0);
    check("arst_irq", 32'(irq), 0);
    check("arst_rdata", read_data, 0);
    @(negedge clk) reset = 0;
    mmio(0, RegBase + 14'h04, 0, e, r); check("post_rst_len", r, 0);
    mmio(0, RegBase + 14'h08, 0, e, r); check("post_rst_drops", r, 0);
    mmio(0, RegBase + 14'h20, 0, e, r); check("post_rst_level", r, 0);
    mmio(0, RegBase + 14'h28, 0, e, r); check("post_rst_txlen", r, 0);

    // Randomized run against a queue-based model.
    offs = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h24, 6'h28, 6'h30,
             6'h34, 6'h0C};
    rx_wr = 0; drops = 0; slot_r = 0; len_r = 0; rx_en = 0; tx_en = 0; pend = 0;
    for (int it = 0; it < 400; it++) begin
      bit do_op, wr, ok, commit, yumi, done, popped, pushed;
      logic [5:0]  o;
      logic [31:0] d, exp_rd;
      int csize;
      do_op  = ($urandom % 4) != 0;
      o      = offs[$urandom % 13];
      wr     = $urandom % 2;
      commit = ($urandom % 3) == 0;
      csize  = $urandom_range(0, 2048);
      yumi   = (txq.size() != 0) && (($urandom % 3) == 0);
      done   = ($urandom % 8) == 0;
      if (o == 6'h24) d = $urandom_range(0, 2);
      else if (o == 6'h28) d = (($urandom % 2) != 0) ? $urandom_range(2046, 2050)
                                                     : $urandom_range(0, 300);
      else d = $urandom_range(0, 1);

      exp_rd = 0;
      ok = 0;
      if (!wr) begin
        ok = 1;
        case (o)
          6'h00: exp_rd = rxq.size() != 0 ? rxq[0].slot : 0;
          6'h04: exp_rd = rxq.size() != 0 ? rxq[0].len : 0;
          6'h08: exp_rd = drops;
          6'h10: exp_rd = 32'(rxq.size() != 0);
          6'h14: exp_rd = 32'(rx_en);
          6'h1C: exp_rd = 32'(txq.size() < 2);
          6'h20: exp_rd = txq.size();
          6'h24: exp_rd = slot_r;
          6'h28: exp_rd = len_r;
          6'h30: exp_rd = 32'(pend);
          6'h34: exp_rd = 32'(tx_en);
          default: ok = 0;
        endcase
      end else begin
        case (o)
          6'h10, 6'h14, 6'h30, 6'h34: ok = 1;
          6'h18: ok = (txq.size() < 2) || yumi;
          6'h24: ok = d < 2;
          6'h28: ok = d <= 2048;
          default: ok = 0;
        endcase
      end

      @(negedge clk);
      addr = RegBase + 14'(o); read_en = do_op && !wr; write_en = do_op && wr;
      write_data = d; rx_commit = commit; rx_commit_size = 12'(csize);
      tx_cmd_yumi = yumi; tx_done = done;
      #1;
      check("rnd_err", 32'(dec_err), 32'(do_op && !ok));
      check("rnd_free_v", 32'(rx_free_v), 32'(rxq.size() < 2));
      check("rnd_free_slot", 32'(rx_free_slot), rx_wr);
      check("rnd_tx_v", 32'(tx_cmd_v), 32'(txq.size() != 0));
      check("rnd_tx_slot", 32'(tx_cmd_slot), txq.size() != 0 ? txq[0].slot : 0);
      check("rnd_tx_size", 32'(tx_cmd_size), txq.size() != 0 ? txq[0].len : 0);
      check("rnd_irq", 32'(irq), 32'(((rxq.size() != 0) && rx_en) || (pend && tx_en)));
      tick();
      read_en = 0; write_en = 0; rx_commit = 0; tx_cmd_yumi = 0; tx_done = 0;
      if (do_op && !wr) check("rnd_rdata", read_data, ok ? exp_rd : 0);

      popped = 0; pushed = 0;
      if (do_op && wr && ok) begin
        case (o)
          6'h10: if (d[0] && rxq.size() != 0) begin void'(rxq.pop_front()); popped = 1; end
          6'h14: rx_en = d[0];
          6'h18: pushed = 1;
          6'h24: slot_r = d;
          6'h28: len_r = d;
          6'h34: tx_en = d[0];
          default: ;
        endcase
      end
      if (commit) begin
        if (rxq.size() < 2 || popped) begin
          rxq.push_back('{rx_wr, csize});
          rx_wr = (rx_wr + 1) % 2;
        end else if (drops < 16'hFFFF) drops++;
      end
      if (yumi) void'(txq.pop_front());
      if (pushed) txq.push_back('{slot_r, len_r});
      if (done) pend = 1;
      else if (do_op && wr && ok && o == 6'h30 && d[0]) pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
